// File: rtl/clock12_set_controller.sv
// clock12_set_controller: time-set sequencer for the 12-hour clock.
// Optional auto-repeat on held up/down: define CLOCK12_SET_AUTOREPEAT_EN.
module clock12_set_controller #(
  parameter int TIMEOUT_SEC  = 30,
  parameter int BLINK_DIV    = 25000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_on,
  input  logic       tick_1hz,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] live_hour,
  input  logic [5:0] live_min,
  input  logic       live_isPM,
  output logic [1:0] current_set_state,
  output logic [3:0] set_hour,
  output logic [5:0] set_min,
  output logic       set_isPM,
  output logic       blink,
  output logic       commit
);

`ifdef CLOCK12_SET_AUTOREPEAT_EN
  localparam logic AR_EN = 1'b1;
`else
  localparam logic AR_EN = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int HW = $clog2(HMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_AMPM = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          set_p_q, up_p_q, dn_p_q;
  logic [3:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic          pm_q, pm_d;
  logic [TW-1:0] tcnt_q;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;
  logic          commit_q;
  logic [HW-1:0] hcnt_q;
  logic          rep_q;

  logic set_ev, up_ev, dn_ev;
  logic hold_act, rep_hit, ar_step;
  logic inc, dec, activity, timeout;

  // Button edge events, hold/auto-repeat strobes and timeout detect
  always_comb begin
    set_ev   = btn_set & ~set_p_q;
    up_ev    = btn_up & ~up_p_q;
    dn_ev    = btn_down & ~dn_p_q;
    hold_act = is_on & ((state_q == S_HOUR) | (state_q == S_MIN)) &
               (btn_up ^ btn_down) & ~set_ev & ~up_ev & ~dn_ev;
    rep_hit  = rep_q ? (hcnt_q == HW'(REPEAT_RATE - 1))
                     : (hcnt_q == HW'(REPEAT_DELAY - 1));
    ar_step  = AR_EN & hold_act & rep_hit;
    inc      = (up_ev & ~dn_ev) | (ar_step & btn_up);
    dec      = (dn_ev & ~up_ev) | (ar_step & btn_down);
    activity = set_ev | up_ev | dn_ev | ar_step;
    timeout  = (state_q != IDLE) & tick_1hz & ~activity &
               (tcnt_q == TW'(TIMEOUT_SEC - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: display off dominates, then set advance, then timeout
  always_comb begin
    state_d = state_q;
    if (!is_on) begin
      state_d = IDLE;
    end else if (set_ev) begin
      case (state_q)
        IDLE:    state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_AMPM;
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  // Outputs straight from registers
  always_comb begin
    current_set_state = state_q;
    set_hour          = hour_q;
    set_min           = min_q;
    set_isPM          = pm_q;
    blink             = blink_q;
    commit            = commit_q;
  end

  // Shadow next values: load on entry, wrap-around edits per field
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    pm_d   = pm_q;
    if (is_on && set_ev && state_q == IDLE) begin
      hour_d = live_hour;
      min_d  = live_min;
      pm_d   = live_isPM;
    end else if (is_on && !set_ev) begin
      unique case (1'b1)
        (state_q == S_HOUR) && inc:
          hour_d = (hour_q == 4'd12) ? 4'd1 : hour_q + 4'd1;
        (state_q == S_HOUR) && dec:
          hour_d = (hour_q == 4'd1) ? 4'd12 : hour_q - 4'd1;
        (state_q == S_MIN) && inc:
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        (state_q == S_MIN) && dec:
          min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        (state_q == S_AMPM) && (inc || dec):
          pm_d = ~pm_q;
        default: ;
      endcase
    end
  end

  // Shadow registers, button history and commit pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      hour_q   <= 4'd12;
      min_q    <= 6'd0;
      pm_q     <= 1'b0;
      set_p_q  <= 1'b0;
      up_p_q   <= 1'b0;
      dn_p_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      hour_q   <= hour_d;
      min_q    <= min_d;
      pm_q     <= pm_d;
      set_p_q  <= btn_set;
      up_p_q   <= btn_up;
      dn_p_q   <= btn_down;
      commit_q <= is_on & set_ev & (state_q == S_AMPM);
    end
  end

  // Inactivity counter in seconds; cleared by activity and state entry
  always_ff @(posedge clk) begin
    if (reset || state_d == IDLE || state_d != state_q || activity)
      tcnt_q <= '0;
    else if (tick_1hz)
      tcnt_q <= tcnt_q + TW'(1);
  end

  // Blink phase: restarts high on each set-state entry, low in IDLE
  always_ff @(posedge clk) begin
    if (reset || state_d == IDLE) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (state_d != state_q) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_q  <= '0;
      blink_q <= ~blink_q;
    end else begin
      bcnt_q  <= bcnt_q + BW'(1);
    end
  end

  // Hold timer: first repeat after the delay, then at the repeat rate
  always_ff @(posedge clk) begin
    if (reset || !hold_act) begin
      hcnt_q <= '0;
      rep_q  <= 1'b0;
    end else if (rep_hit) begin
      hcnt_q <= '0;
      rep_q  <= 1'b1;
    end else begin
      hcnt_q <= hcnt_q + HW'(1);
    end
  end

endmodule

// File: tb/tb_clock12_set_controller.sv
// tb_clock12_set_controller: random and directed checks
// against a behavioural model of the time-set procedure.
module tb_clock12_set_controller;

  localparam int TO = 3;
  localparam int BD = 5;
  localparam int RD = 8;
  localparam int RR = 4;
`ifdef CLOCK12_SET_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       is_on = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] live_hour = 4'd10;
  logic [5:0] live_min = 6'd45;
  logic       live_isPM = 1'b1;
  logic [1:0] current_set_state;
  logic [3:0] set_hour;
  logic [5:0] set_min;
  logic       set_isPM;
  logic       blink;
  logic       commit;

  int nvec = 0;
  int nerr = 0;

  int m_st, m_h, m_m, m_pm, m_c, m_n, m_sec, m_held;
  bit ps, pu, pd;

  clock12_set_controller #(
    .TIMEOUT_SEC(TO),
    .BLINK_DIV(BD),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .is_on(is_on),
    .tick_1hz(tick_1hz),
    .btn_set(btn_set),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .live_hour(live_hour),
    .live_min(live_min),
    .live_isPM(live_isPM),
    .current_set_state(current_set_state),
    .set_hour(set_hour),
    .set_min(set_min),
    .set_isPM(set_isPM),
    .blink(blink),
    .commit(commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: one clock of the set procedure from the rules
  task automatic model_clk();
    bit es, eu, ed, act, hold;
    int dir;
    if (reset) begin
      m_st = 0; m_h = 12; m_m = 0; m_pm = 0; m_c = 0;
      m_n = 0; m_sec = 0; m_held = 0;
      ps = 0; pu = 0; pd = 0;
      return;
    end
    es = btn_set && !ps;
    eu = btn_up && !pu;
    ed = btn_down && !pd;
    ps = btn_set; pu = btn_up; pd = btn_down;
    m_c = 0;
    if (!is_on) begin
      m_st = 0; m_sec = 0; m_held = 0;
    end else if (es) begin
      if (m_st == 0) begin
        m_h = live_hour; m_m = live_min; m_pm = live_isPM;
      end
      if (m_st == 3) m_c = 1;
      m_st = (m_st + 1) % 4;
      m_n = 0; m_sec = 0; m_held = 0;
    end else if (m_st != 0) begin
      act = eu || ed;
      dir = 0;
      if (eu && !ed) dir = 1;
      else if (ed && !eu) dir = -1;
      hold = (m_st == 1 || m_st == 2) &&
             (btn_up != btn_down) && !act;
      if (hold) begin
        m_held++;
        if (AR && (m_held == RD ||
            (m_held > RD && (m_held - RD) % RR == 0))) begin
          dir = btn_up ? 1 : -1;
          act = 1;
        end
      end else begin
        m_held = 0;
      end
      if (dir != 0) begin
        case (m_st)
          1: m_h = ((m_h - 1 + dir + 12) % 12) + 1;
          2: m_m = (m_m + dir + 60) % 60;
          default: m_pm = !m_pm;
        endcase
      end
      m_n++;
      if (act) m_sec = 0;
      else if (tick_1hz) begin
        m_sec++;
        if (m_sec == TO) m_st = 0;
      end
    end else begin
      m_held = 0;
    end
  endtask

  task automatic step();
    int eb;
    @(posedge clk);
    model_clk();
    #1;
    eb = (m_st != 0 && ((m_n / BD) % 2 == 0)) ? 1 : 0;
    chk("state", current_set_state, m_st);
    chk("hour", set_hour, m_h);
    chk("min", set_min, m_m);
    chk("ampm", set_isPM, m_pm);
    chk("blink", blink, eb);
    chk("commit", commit, m_c);
  endtask

  task automatic press_set();
    btn_set = 1; step(); btn_set = 0; step();
  endtask
  task automatic press_up();
    btn_up = 1; step(); btn_up = 0; step();
  endtask
  task automatic press_dn();
    btn_down = 1; step(); btn_down = 0; step();
  endtask

  initial begin
    reset = 1;
    step(); step();
    reset = 0;
    step();
    chk("rst_state", current_set_state, 0);
    chk("rst_hour", set_hour, 12);

    // Enter set mode from 10:45 PM
    btn_set = 1; step();
    chk("ld_state", current_set_state, 1);
    chk("ld_hour", set_hour, 10);
    chk("ld_min", set_min, 45);
    chk("ld_pm", set_isPM, 1);
    chk("ld_blink", blink, 1);
    chk("ld_commit", commit, 0);
    btn_set = 0; step();

    // Hour wrap 12->1, then 1->12->11
    press_up(); press_up();
    chk("hr12", set_hour, 12);
    press_up();
    chk("hr_wrap_up", set_hour, 1);
    press_dn();
    chk("hr_wrap_dn", set_hour, 12);
    press_dn();
    chk("hr11", set_hour, 11);

    // Minute wrap and simultaneous up+down
    press_set();
    for (int i = 0; i < 14; i++) press_up();
    chk("min59", set_min, 59);
    press_up();
    chk("min_wrap_up", set_min, 0);
    press_dn();
    chk("min_wrap_dn", set_min, 59);
    btn_up = 1; btn_down = 1; step();
    btn_up = 0; btn_down = 0; step();
    chk("min_both", set_min, 59);

    // AM/PM toggle then commit
    press_set();
    press_up();
    chk("pm_tog", set_isPM, 0);
    btn_set = 1; step();
    chk("cm_pulse", commit, 1);
    chk("cm_state", current_set_state, 0);
    btn_set = 0; step();
    chk("cm_once", commit, 0);

    // Timeout in SET_MIN
    press_set(); press_set();
    for (int i = 0; i < TO; i++) begin
      tick_1hz = 1; step();
      if (i == TO - 2) chk("to_hold", current_set_state, 2);
      tick_1hz = 0; step();
    end
    chk("to_idle", current_set_state, 0);

    // Display off during SET_HOUR
    press_set();
    is_on = 0; step();
    chk("off_idle", current_set_state, 0);
    is_on = 1; step();

    // Held up in SET_MIN from 0
    live_min = 0;
    press_set(); press_set();
    btn_up = 1; step();
    chk("ar_edge", set_min, 1);
    for (int i = 1; i < 20; i++) step();
    btn_up = 0; step();
    chk("ar_final", set_min, AR ? 4 : 1);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) btn_set = ~btn_set;
      if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
      tick_1hz = ($urandom_range(0, 7) == 0);
      is_on = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 15) == 0) begin
        live_hour = 4'($urandom_range(1, 12));
        live_min  = 6'($urandom_range(0, 59));
        live_isPM = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clock12_set_controller.md
Name: clock12_set_controller

Overview:
- Sequences the user time-set procedure for the 12-hour clock.
- Takes debounced button levels and the live time.
- Holds shadow hour, minute and AM/PM registers while editing, and drives current_set_state, set_isPM and a blink enable to the 12-hour display decoder.
- Issues a one-cycle commit pulse to the timekeeping counter when the user confirms.

Parameters:
- TIMEOUT_SEC, 30: seconds of button inactivity in any set state before abort.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- REPEAT_DELAY, 50000000: clk cycles a held up/down must stay asserted before auto-repeat (feature only).
- REPEAT_RATE, 10000000: clk cycles between auto-repeat steps (feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- is_on  in  1  clock display enabled; low forces IDLE
- tick_1hz  in  1  one-cycle pulse per second
- btn_set  in  1  debounced level; rising edge advances state
- btn_up  in  1  debounced level; rising edge increments field
- btn_down  in  1  debounced level; rising edge decrements field
- live_hour  in  4  current hour, 1..12
- live_min  in  6  current minute, 0..59
- live_isPM  in  1  current AM/PM
- current_set_state  out  2  0=IDLE 1=SET_HOUR 2=SET_MIN 3=SET_AMPM
- set_hour  out  4  shadow hour, 1..12
- set_min  out  6  shadow minute, 0..59
- set_isPM  out  1  shadow AM/PM
- blink  out  1  blink phase for the field being edited
- commit  out  1  one-cycle pulse: load set_* into timekeeper

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: current_set_state=0, set_hour=12, set_min=0, set_isPM=0, blink=0, commit=0. Edge detectors, timeout counter and blink counter also clear.
- Edge detection: internal registered copies of the button levels. An event is level high with the previous sample low. Outputs respond 1 cycle after the edge sample.
- FSM transitions:
  - IDLE: a btn_set edge copies live_* into the shadow registers and moves to SET_HOUR.
  - SET_HOUR: btn_set edge moves to SET_MIN.
  - SET_MIN: btn_set edge moves to SET_AMPM.
  - SET_AMPM: btn_set edge moves to IDLE and asserts commit for exactly that transition cycle.
- Edits, applied only in the matching state:
  - SET_HOUR up: 1→2…11→12, 12→1. Down: 12→11…2→1, 1→12.
  - SET_MIN up: 59→0. Down: 0→59.
  - SET_AMPM: up or down toggles set_isPM.
- Up and down edges in the same cycle: no change; the pair still counts as activity.
- btn_set edge coincident with an up/down edge: state advance wins; the edit is ignored.
- Edits in IDLE are ignored; up/down are ignored there entirely.
- Timeout:
  - Counter clears on any button edge and on entry to a set state.
  - It increments on tick_1hz while not IDLE.
  - On reaching TIMEOUT_SEC, return to IDLE with no commit. Shadows keep their values.
- is_on low: next cycle state=IDLE, commit=0, counters cleared. No commit is generated by an abort.
- Blink:
  - Counter runs only in set states and toggles blink every BLINK_DIV cycles.
  - blink=1 on entry to every set state, including each advance.
  - blink=0 in IDLE.
- commit never asserts in two consecutive cycles.
- Shadows in IDLE follow nothing; they hold the last values.

Optional Feature:
- Macro: CLOCK12_SET_AUTOREPEAT_EN.
- Defined:
  - While exactly one of btn_up/btn_down stays high in SET_HOUR or SET_MIN, a hold counter runs.
  - After REPEAT_DELAY cycles it generates one step, then one step every REPEAT_RATE cycles until release.
  - Each step applies the same wrap rules and clears the timeout.
  - No auto-repeat in SET_AMPM.
- Undefined: only rising edges step; holding a button yields exactly one step. The REPEAT_* parameters are unused.

Test Plan:
- Reset, then live 10:45 PM, then a btn_set edge → state=1, set_hour=10, set_min=45, set_isPM=1, blink=1, commit=0.
- In SET_HOUR at 12, one up edge → set_hour=1. Then two down edges → 1→12→11.
- In SET_MIN at 59, up → 0. Then down → 59. Simultaneous up+down → stays 59.
- Full sequence of three more btn_set edges after an AMPM toggle → commit high for exactly one cycle with set_isPM inverted, then state=0.
- In SET_MIN, no buttons for TIMEOUT_SEC tick_1hz pulses (use TIMEOUT_SEC=3) → state=0 on the third tick, commit never asserted. With is_on dropped mid-SET_HOUR → state=0 next cycle.
- With CLOCK12_SET_AUTOREPEAT_EN and REPEAT_DELAY=8, REPEAT_RATE=4: hold up 20 cycles in SET_MIN from 0 → set_min=1 at edge, 2 at hold+8, 3 at +12, 4 at +16. Without the macro → set_min=1.
